// File: rtl/nios2_ocimem_arb_pkg.sv
// Shared types and jdo field positions for the OCI memory arbiter.
package nios2_ocimem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CAP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_J = 1'b0,
    REQ_A = 1'b1
  } req_id_e;

  localparam int JDO_W        = 38;
  localparam int JDO_RD_FLAG  = 34;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_ADDR_LSB = 26;

endpackage

// File: rtl/nios2_ocimem_rr_arb.sv
// Two-requester round-robin grant; the pointer remembers the last winner.
module nios2_ocimem_rr_arb
  import nios2_ocimem_arb_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    en_i,
  input  logic    req_j_i,
  input  logic    req_a_i,
  output logic    gnt_valid_o,
  output req_id_e gnt_id_o
);

  req_id_e last_q;

  always_comb begin
    gnt_valid_o = en_i && (req_j_i || req_a_i);
    if (req_j_i && req_a_i) begin
      gnt_id_o = (last_q == REQ_A) ? REQ_J : REQ_A;
    end else if (req_j_i) begin
      gnt_id_o = REQ_J;
    end else begin
      gnt_id_o = REQ_A;
    end
  end

  // Reset to "A last" so JTAG wins the first conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ_A;
    end else if (gnt_valid_o) begin
      last_q <= gnt_id_o;
    end
  end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG path and the Avalon debug slave.
// Optional: define NIOS2_OCIMEM_ARB_AUTOINC_EN to post-increment the JTAG address on writes.
module nios2_ocimem_arbiter
  import nios2_ocimem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [JDO_W-1:0]  jdo,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  arb_state_e        state_q;
  req_id_e           own_q;
  logic              acc_rd_q;

  logic              slot_vld_q;
  logic              slot_rd_q;
  logic [ADDR_W-1:0] slot_addr_q;
  logic [DATA_W-1:0] slot_data_q;
  logic [ADDR_W-1:0] jaddr_q;
  logic [ADDR_W-1:0] jaddr_d;
  logic              overrun_q;

  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_wren_q;
  logic [DATA_W-1:0] avs_readdata_q;
  logic              avs_rdv_q;
  logic [DATA_W-1:0] mondreg_q;
  logic              mon_rdy_q;

  logic              gnt_valid;
  req_id_e           gnt_id;
  logic              gnt_j;
  logic              take_any;
  logic              cmd_new;
  logic [ADDR_W-1:0] jdo_addr;
  logic [DATA_W-1:0] jdo_data;
  logic              unused_jdo;

  assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_data   = jdo[JDO_DATA_LSB +: DATA_W];
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_FLAG+1], jdo[JDO_DATA_LSB-1:0]};

  assign take_any = take_action_ocimem_a | take_action_ocimem_b;
  // An a-pulse always wins over a same-cycle b-pulse; it only queues work when the read flag is set.
  assign cmd_new  = take_action_ocimem_a ? jdo[JDO_RD_FLAG] : take_action_ocimem_b;

  nios2_ocimem_rr_arb u_rr_arb (
    .clk         (clk),
    .reset       (reset),
    .en_i        (state_q == IDLE),
    .req_j_i     (slot_vld_q),
    .req_a_i     (avs_read | avs_write),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  assign gnt_j = gnt_valid && (gnt_id == REQ_J);

  always_comb begin
    jaddr_d = jaddr_q;
`ifdef NIOS2_OCIMEM_ARB_AUTOINC_EN
    if (state_q == ACC && own_q == REQ_J && !acc_rd_q) begin
      jaddr_d = jaddr_q + ADDR_W'(1);
    end
`endif
    if (take_action_ocimem_a) begin
      jaddr_d = jdo_addr;
    end
  end

  // Pending slot: the queued command takes the address as it will be after this cycle,
  // so a b-pulse during an auto-incrementing write still targets the next word.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_vld_q  <= 1'b0;
      slot_rd_q   <= 1'b0;
      slot_addr_q <= '0;
      slot_data_q <= '0;
      jaddr_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      jaddr_q <= jaddr_d;
      if (take_any && slot_vld_q && !gnt_j) begin
        overrun_q <= 1'b1;
      end
      if (cmd_new) begin
        slot_vld_q  <= 1'b1;
        slot_rd_q   <= take_action_ocimem_a;
        slot_addr_q <= jaddr_d;
        if (!take_action_ocimem_a) begin
          slot_data_q <= jdo_data;
        end
      end else if (gnt_j) begin
        slot_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      own_q          <= REQ_A;
      acc_rd_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      ram_wren_q     <= 1'b0;
      avs_readdata_q <= '0;
      avs_rdv_q      <= 1'b0;
      mondreg_q      <= '0;
      mon_rdy_q      <= 1'b0;
    end else begin
      avs_rdv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            state_q <= ACC;
            own_q   <= gnt_id;
            if (gnt_j) begin
              acc_rd_q   <= slot_rd_q;
              ram_addr_q <= slot_addr_q;
              ram_wren_q <= !slot_rd_q;
              if (!slot_rd_q) begin
                ram_wdata_q <= slot_data_q;
              end
            end else begin
              acc_rd_q   <= !avs_write;
              ram_addr_q <= avs_address;
              ram_wren_q <= avs_write;
              if (avs_write) begin
                ram_wdata_q <= avs_writedata;
              end
            end
          end
        end
        ACC: begin
          ram_wren_q <= 1'b0;
          state_q    <= acc_rd_q ? CAP : IDLE;
        end
        CAP: begin
          state_q <= IDLE;
          if (own_q == REQ_J) begin
            mondreg_q <= ram_rdata;
            mon_rdy_q <= 1'b1;
          end else begin
            avs_readdata_q <= ram_rdata;
            avs_rdv_q      <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (take_any) begin
        mon_rdy_q <= 1'b0;
      end
    end
  end

  // Reset gates the registered strobes so an aborted access never reaches the RAM or the master.
  assign ram_wren          = ram_wren_q & ~reset;
  assign avs_waitrequest   = reset | !(state_q == ACC && own_q == REQ_A);
  assign ram_addr          = ram_addr_q;
  assign ram_wdata         = ram_wdata_q;
  assign avs_readdata      = avs_readdata_q;
  assign avs_readdatavalid = avs_rdv_q;
  assign MonDReg           = mondreg_q;
  assign monitor_ready     = mon_rdy_q;
  assign jtag_overrun      = overrun_q;

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Directed bench for nios2_ocimem_arbiter: vector table plus hand-written contention/reset sequences.
module tb_nios2_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [37:0] jdo = '0;
  logic [7:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        jtag_overrun;

  int vec_cnt = 0;
  int miss_cnt = 0;

  nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                  (clk),
    .reset                (reset),
    .take_action_ocimem_a (take_action_ocimem_a),
    .take_action_ocimem_b (take_action_ocimem_b),
    .jdo                  (jdo),
    .avs_address          (avs_address),
    .avs_read             (avs_read),
    .avs_write            (avs_write),
    .avs_writedata        (avs_writedata),
    .avs_waitrequest      (avs_waitrequest),
    .avs_readdata         (avs_readdata),
    .avs_readdatavalid    (avs_readdatavalid),
    .ram_addr             (ram_addr),
    .ram_wren             (ram_wren),
    .ram_wdata            (ram_wdata),
    .ram_rdata            (ram_rdata),
    .MonDReg              (MonDReg),
    .monitor_ready        (monitor_ready),
    .jtag_overrun         (jtag_overrun)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
    return {3'b000, rd, addr, 26'd0};
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    return {3'b000, data, 3'b000};
  endfunction

  task automatic jpulse(input logic is_a, input logic [37:0] w);
    jdo = w;
    take_action_ocimem_a = is_a;
    take_action_ocimem_b = !is_a;
    step();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic avs_acc(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [31:0] exp);
    int cyc;
    avs_address = a;
    avs_writedata = d;
    avs_write = wr;
    avs_read = !wr;
    cyc = 0;
    while (avs_waitrequest && cyc < 20) begin
      step();
      cyc++;
    end
    chk("avs_wait_latency", cyc, 32'd1);
    step();
    avs_write = 1'b0;
    avs_read = 1'b0;
    if (!wr) begin
      chk1("avs_rdv_early", avs_readdatavalid, 1'b0);
      step();
      chk1("avs_rdv", avs_readdatavalid, 1'b1);
      chk("avs_readdata", avs_readdata, exp);
      step();
      chk1("avs_rdv_pulse", avs_readdatavalid, 1'b0);
    end else begin
      step();
    end
  endtask

  task automatic jtag_rd(input logic [7:0] a, input logic [31:0] exp);
    int cyc;
    jpulse(1'b1, jdo_a(a, 1'b1));
    chk1("mon_rdy_clear", monitor_ready, 1'b0);
    cyc = 1;
    while (!monitor_ready && cyc < 20) begin
      step();
      cyc++;
    end
    chk("jtag_rd_latency", cyc, 32'd4);
    chk("MonDReg", MonDReg, exp);
  endtask

  task automatic jtag_wr(input logic [31:0] d);
    jpulse(1'b0, jdo_b(d));
    step();
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    #1;
  endtask

  // Runs until both a JTAG read and an Avalon read have completed, recording completion cycles.
  task automatic run_conflict(output int j_cyc, output int a_cyc, output logic [31:0] a_data);
    bit saw_low;
    bit drop;
    saw_low = 1'b0;
    j_cyc = -1;
    a_cyc = -1;
    a_data = '0;
    for (int c = 0; c < 30; c++) begin
      if (!monitor_ready) saw_low = 1'b1;
      else if (saw_low && j_cyc < 0) j_cyc = c;
      if (avs_readdatavalid && a_cyc < 0) begin
        a_cyc = c;
        a_data = avs_readdata;
      end
      drop = avs_read && !avs_waitrequest;
      if (j_cyc >= 0 && a_cyc >= 0) break;
      step();
      take_action_ocimem_a = 1'b0;
      if (drop) avs_read = 1'b0;
    end
  endtask

  typedef enum int {OP_AWR, OP_ARD, OP_JADDR, OP_JRD, OP_JWR} op_e;
  typedef struct {
    op_e         op;
    logic [7:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int j1, a1, j2, a2, cyc;
    logic [31:0] d1, d2;
    bit seen_first;

    vecs[0]  = '{OP_AWR,   8'h05, 32'h1234_5678};
    vecs[1]  = '{OP_ARD,   8'h05, 32'h1234_5678};
    vecs[2]  = '{OP_AWR,   8'h10, 32'hCAFE_F00D};
    vecs[3]  = '{OP_JRD,   8'h10, 32'hCAFE_F00D};
    vecs[4]  = '{OP_JADDR, 8'h30, 32'h0};
    vecs[5]  = '{OP_JWR,   8'h30, 32'hA5A5_5A5A};
    vecs[6]  = '{OP_ARD,   8'h30, 32'hA5A5_5A5A};
    vecs[7]  = '{OP_AWR,   8'h00, 32'hDEAD_BEEF};
    vecs[8]  = '{OP_JRD,   8'h00, 32'hDEAD_BEEF};
    vecs[9]  = '{OP_AWR,   8'hFF, 32'h0F0F_0F0F};
    vecs[10] = '{OP_JRD,   8'hFF, 32'h0F0F_0F0F};
    vecs[11] = '{OP_JRD,   8'h05, 32'h1234_5678};

    step();
    do_reset();
    chk1("rst_waitrequest", avs_waitrequest, 1'b1);
    chk1("rst_readdatavalid", avs_readdatavalid, 1'b0);
    chk1("rst_ram_wren", ram_wren, 1'b0);
    chk1("rst_monitor_ready", monitor_ready, 1'b0);
    chk1("rst_overrun", jtag_overrun, 1'b0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_MonDReg", MonDReg, 32'h0);
    step();

    for (int i = 0; i < 12; i++) begin
      case (vecs[i].op)
        OP_AWR:   avs_acc(1'b1, vecs[i].addr, vecs[i].data, 32'h0);
        OP_ARD:   avs_acc(1'b0, vecs[i].addr, 32'h0, vecs[i].data);
        OP_JADDR: jpulse(1'b1, jdo_a(vecs[i].addr, 1'b0));
        OP_JRD:   jtag_rd(vecs[i].addr, vecs[i].data);
        default:  jtag_wr(vecs[i].data);
      endcase
      step();
    end

    // Contention: fresh pointer, J pending before A arrives -> J then A.
    avs_acc(1'b1, 8'h40, 32'h1111_1111, 32'h0);
    avs_acc(1'b1, 8'h41, 32'h2222_2222, 32'h0);
    do_reset();
    step();
    jpulse(1'b1, jdo_a(8'h40, 1'b1));
    avs_address = 8'h41;
    avs_read = 1'b1;
    run_conflict(j1, a1, d1);
    chk("rr1_j_done_cycle", j1, 32'd3);
    chk("rr1_a_done_cycle", a1, 32'd6);
    chk("rr1_MonDReg", MonDReg, 32'h1111_1111);
    chk("rr1_readdata", d1, 32'h2222_2222);
    step();
    step();

    // Both requests issued in the same idle cycle -> A then J.
    jdo = jdo_a(8'h41, 1'b1);
    take_action_ocimem_a = 1'b1;
    avs_address = 8'h40;
    avs_read = 1'b1;
    run_conflict(j2, a2, d2);
    chk("rr2_a_done_cycle", a2, 32'd3);
    chk("rr2_j_done_cycle", j2, 32'd6);
    chk("rr2_MonDReg", MonDReg, 32'h2222_2222);
    chk("rr2_readdata", d2, 32'h1111_1111);
    chk1("rr2_no_overrun", jtag_overrun, 1'b0);
    step();

    // Overrun: two a-pulses while an Avalon read holds the RAM.
    avs_acc(1'b1, 8'h50, 32'h5555_5555, 32'h0);
    avs_acc(1'b1, 8'h51, 32'hAAAA_0051, 32'h0);
    avs_acc(1'b1, 8'h52, 32'h0052_0052, 32'h0);
    avs_address = 8'h52;
    avs_read = 1'b1;
    chk1("ovr_wait_c0", avs_waitrequest, 1'b1);
    step();
    chk1("ovr_wait_c1", avs_waitrequest, 1'b0);
    jdo = jdo_a(8'h50, 1'b1);
    take_action_ocimem_a = 1'b1;
    step();
    avs_read = 1'b0;
    jdo = jdo_a(8'h51, 1'b1);
    step();
    take_action_ocimem_a = 1'b0;
    chk1("ovr_avs_rdv", avs_readdatavalid, 1'b1);
    chk("ovr_avs_readdata", avs_readdata, 32'h0052_0052);
    seen_first = 1'b0;
    cyc = 0;
    while (!monitor_ready && cyc < 20) begin
      if (MonDReg == 32'h5555_5555) seen_first = 1'b1;
      step();
      cyc++;
    end
    repeat (4) begin
      if (MonDReg == 32'h5555_5555) seen_first = 1'b1;
      step();
    end
    chk1("ovr_monitor_ready", monitor_ready, 1'b1);
    chk1("ovr_sticky", jtag_overrun, 1'b1);
    chk("ovr_MonDReg", MonDReg, 32'hAAAA_0051);
    chk1("ovr_first_dropped", seen_first, 1'b0);

    // Reset during the ACC cycle of a write must leave the RAM untouched.
    avs_acc(1'b1, 8'h60, 32'h6060_6060, 32'h0);
    avs_address = 8'h60;
    avs_writedata = 32'hBADB_AD00;
    avs_write = 1'b1;
    step();
    chk1("abort_wren_pre", ram_wren, 1'b1);
    reset = 1'b1;
    avs_write = 1'b0;
    #1;
    chk1("abort_wren_gated", ram_wren, 1'b0);
    chk1("abort_waitrequest", avs_waitrequest, 1'b1);
    step();
    reset = 1'b0;
    #1;
    chk1("abort_overrun_clr", jtag_overrun, 1'b0);
    step();
    avs_acc(1'b0, 8'h60, 32'h0, 32'h6060_6060);

    // Address wrap with consecutive b-pulses.
    jpulse(1'b1, jdo_a(8'hFF, 1'b0));
    step();
    jtag_wr(32'h0000_0001);
    jtag_wr(32'h0000_0002);
    step();
`ifdef NIOS2_OCIMEM_ARB_AUTOINC_EN
    avs_acc(1'b0, 8'hFF, 32'h0, 32'h0000_0001);
    avs_acc(1'b0, 8'h00, 32'h0, 32'h0000_0002);
`else
    avs_acc(1'b0, 8'hFF, 32'h0, 32'h0000_0002);
    avs_acc(1'b0, 8'h00, 32'h0, 32'hDEAD_BEEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/nios2_ocimem_arbiter.md
# nios2_ocimem_arbiter

Shares the single-port on-chip debug RAM (OCI memory, 1-cycle read latency) between the JTAG debug path and the CPU-side Avalon-MM debug slave port. JTAG commands arrive as take_action_ocimem_a/b pulses with the 38-bit jdo shift word, already in the system clock domain. The block latches them into a one-entry pending slot and arbitrates round-robin against Avalon requests. It returns JTAG read data through MonDReg and monitor_ready.

## Interface
- ADDR_W, 8, OCI RAM word-address width (ADDR_W ≤ 8)
- DATA_W, 32, RAM/Avalon data width (fixed 32; jdo packing depends on it)
- clk  in  1  system clock; everything is clocked on its rising edge
- reset  in  1  synchronous, active-high reset
- take_action_ocimem_a  in  1  JTAG address-load pulse: addr ← jdo[ADDR_W+25:26]; if jdo[34]=1 also queues a read
- take_action_ocimem_b  in  1  JTAG write pulse: data jdo[34:3] to current JTAG address
- jdo  in  38  JTAG data word
- avs_address  in  ADDR_W  Avalon word address
- avs_read  in  1  Avalon read request
- avs_write  in  1  Avalon write request
- avs_writedata  in  32  Avalon write data
- avs_waitrequest  out  1  high while the Avalon request is not yet granted
- avs_readdata  out  32  Avalon read data
- avs_readdatavalid  out  1  one-cycle read-data strobe
- ram_addr  out  ADDR_W  RAM address
- ram_wren  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after the address
- MonDReg  out  32  last JTAG read data
- monitor_ready  out  1  JTAG read complete
- jtag_overrun  out  1  sticky: new JTAG command arrived while one was still pending

## Operation
- FSM states: IDLE, ACC, CAP.
- IDLE: if any request is present, grant one and go to ACC.
- ACC: drive ram_addr, plus ram_wren/ram_wdata for writes.
  - Write: go to IDLE.
  - Read: go to CAP.
- CAP: capture ram_rdata, then go to IDLE.
- Requesters:
  - J: JTAG pending slot (valid, rw, addr, data).
  - A: avs_read | avs_write held asserted.
- Arbitration in IDLE:
  - Only one requester present: grant it.
  - Both present: grant the one not granted last (round-robin pointer). Pointer resets to "A last", so J wins the first conflict.
- take_action_ocimem_a: loads the JTAG address register; with jdo[34]=1, sets pending read. Clears monitor_ready.
- take_action_ocimem_b: sets pending write with jdo[34:3]. Clears monitor_ready.
- A take_action while the slot is valid and not yet granted:
  - New command overwrites the slot.
  - jtag_overrun sets.
- A take_action during J's ACC/CAP: queued as a new pending entry; no overrun.
- JTAG read in CAP: MonDReg ← ram_rdata and monitor_ready ← 1.
- Avalon read in CAP: avs_readdata ← ram_rdata and avs_readdatavalid pulses.
- Avalon master holds the request stable while waitrequest=1 (Avalon rule); the block does not check this.
- Simultaneous take_action_ocimem_a and _b in one cycle: _a takes precedence; _b is ignored.

## Timing
- Reset values:
  - FSM = IDLE, pending slot empty, RR pointer = A.
  - JTAG address = 0, MonDReg = 0.
  - monitor_ready, jtag_overrun, avs_readdatavalid, ram_wren = 0.
  - avs_waitrequest = 1; ram_addr, ram_wdata, avs_readdata = 0.
- Reset asserted mid-access aborts the access. No write is issued in the reset cycle; the pending command is lost.
- avs_waitrequest:
  - Combinationally low only in the ACC cycle of an A grant; high otherwise.
  - Minimum Avalon write latency is 1 cycle (request cycle = IDLE, ACC next).
- Avalon read: request seen in IDLE (cycle 0), ACC at cycle 1, CAP at cycle 2. avs_readdatavalid=1 in cycle 3 (registered).
- JTAG read: pulse at cycle 0, slot valid at cycle 1, monitor_ready=1 by cycle 4 when uncontended.
- Back-to-back throughput: writes, 1 per 2 cycles; reads, 1 per 3 cycles.

## Configuration
- NIOS2_OCIMEM_ARB_AUTOINC_EN defined:
  - JTAG address increments by 1 in the cycle a J write leaves ACC.
  - Wraps from 2^ADDR_W−1 to 0.
  - Consecutive take_action_ocimem_b pulses fill sequential words.
- Undefined: JTAG address changes only on take_action_ocimem_a.

## Structure
- Package nios2_ocimem_arb_pkg:
  - FSM state enum.
  - jdo field constants: JDO_RD_FLAG=34, JDO_DATA_LSB=3, JDO_ADDR_LSB=26.
  - requester-id type.
- Sub-module nios2_ocimem_rr_arb: 2-requester round-robin grant with pointer update on grant.

## Test plan
- Reset held 3 cycles → all outputs at reset values; avs_waitrequest=1.
- Avalon write 0x12345678 to addr 0x05, then read 0x05 → waitrequest low 1 cycle each; readdatavalid 3 cycles after the read request with readdata=0x12345678.
- JTAG a-pulse with jdo addr 0x10 and rd flag, after RAM[0x10]=0xCAFEF00D → MonDReg=0xCAFEF00D and monitor_ready=1 within 4 cycles.
- Avalon read and JTAG read requested in the same cycle, repeated twice → grants J, A, then A, J; both data correct.
- AUTOINC_EN: address 0xFF, two b-pulses with data 1 and 2 → RAM[0xFF]=1, RAM[0x00]=2. Without the macro → RAM[0xFF]=2.
- Two a-pulses while the slot is blocked by an Avalon access → jtag_overrun=1, only the second read is performed; reset asserted mid-ACC write → RAM unchanged.
